// File: rtl/agc_timepulse_ctrl.sv
// AGC timepulse sequencer: one-hot T01..T(NUM_TP) train split into PHASES
// clocks each, memory-cycle (MCT) counting, single-MCT step/halt handshake
// and GOJAM restart.
module agc_timepulse_ctrl #(
  parameter int unsigned NUM_TP = 12,
  parameter int unsigned PHASES = 2,
  parameter int unsigned CW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              gojam,
  output logic [NUM_TP-1:0] tp,
  output logic              ph1,
  output logic              ph2,
  output logic              mct_end,
  output logic              halted,
  output logic              gojam_cycle,
  output logic [CW-1:0]     mct_count
);

  localparam int unsigned       PW       = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0]     PH_LAST  = PW'(PHASES - 1);
  localparam logic [NUM_TP-1:0] TP_FIRST = NUM_TP'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] phase;
  logic          running;
  logic          phase_last;
  logic          restart;
  logic          mct_done;

  // Decoded status, purely from registered state
  always_comb begin
    running    = (state == S_RUN);
    phase_last = (phase == PH_LAST);
    ph1        = running & (phase == '0);
    ph2        = running & phase_last;
    mct_end    = tp[NUM_TP-1] & phase_last;
    halted     = (state == S_HALT);
    // GOJAM only acts once the sequencer has been started
    restart    = gojam & (state != S_IDLE);
    // tp is nonzero only in RUN, so mct_end already implies RUN
    mct_done   = mct_end & ~gojam;
  end

  // Sequencer FSM: state, timepulse shift register and phase counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tp    <= '0;
      phase <= '0;
    end else if (restart) begin
      state <= S_RUN;
      tp    <= TP_FIRST;
      phase <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_RUN;
            tp    <= TP_FIRST;
            phase <= '0;
          end
        end
        S_RUN: begin
          if (!phase_last) begin
            phase <= phase + PW'(1);
          end else begin
            phase <= '0;
            if (!tp[NUM_TP-1]) begin
              tp <= tp << 1;
            end else if (!run) begin
              state <= S_IDLE;
              tp    <= '0;
            end else if (step_mode) begin
              state <= S_HALT;
              tp    <= '0;
            end else begin
              tp <= TP_FIRST;
            end
          end
        end
        S_HALT: begin
          if (!run) begin
            state <= S_IDLE;
          end else if (step_req) begin
            state <= S_RUN;
            tp    <= TP_FIRST;
            phase <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          tp    <= '0;
          phase <= '0;
        end
      endcase
    end
  end

  // MCT counter and GOJAM-origin flag; an aborted MCT is never counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mct_count   <= '0;
      gojam_cycle <= 1'b0;
    end else if (restart) begin
      gojam_cycle <= 1'b1;
    end else if (mct_done) begin
      mct_count   <= mct_count + CW'(1);
      gojam_cycle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_agc_timepulse_ctrl.sv
// Self-checking bench for agc_timepulse_ctrl: directed scenarios plus
// randomized traffic against a cycle-index reference model.
module tb_agc_timepulse_ctrl;

  localparam int unsigned NTP = 12;
  localparam int unsigned NPH = 2;
  localparam int unsigned L   = NTP * NPH;

  logic clk = 1'b0;
  logic rst, run, step_mode, step_req, gojam;

  logic [NTP-1:0] tp, tp_w;
  logic ph1, ph2, mct_end, halted, gojam_cycle;
  logic ph1_w, ph2_w, mct_end_w, halted_w, gojam_cycle_w;
  logic [15:0] mct_count;
  logic [3:0]  mct_count_w;

  agc_timepulse_ctrl #(.NUM_TP(NTP), .PHASES(NPH), .CW(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode),
    .step_req(step_req), .gojam(gojam), .tp(tp), .ph1(ph1), .ph2(ph2),
    .mct_end(mct_end), .halted(halted), .gojam_cycle(gojam_cycle),
    .mct_count(mct_count)
  );

  // Narrow-counter copy to exercise wrap-around in a short run
  agc_timepulse_ctrl #(.NUM_TP(NTP), .PHASES(NPH), .CW(4)) dut_w (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode),
    .step_req(step_req), .gojam(gojam), .tp(tp_w), .ph1(ph1_w), .ph2(ph2_w),
    .mct_end(mct_end_w), .halted(halted_w), .gojam_cycle(gojam_cycle_w),
    .mct_count(mct_count_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 halt; idx = clock within MCT
  int          m_mode;
  int unsigned m_idx;
  bit          m_gc;
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_gc = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (gojam && m_mode != 0) begin
      m_mode = 1; m_idx = 0; m_gc = 1;
    end else if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_idx = 0; end
    end else if (m_mode == 1) begin
      if (m_idx == L - 1) begin
        m_cnt++;
        m_gc  = 0;
        m_idx = 0;
        if (!run) m_mode = 0;
        else if (step_mode) m_mode = 2;
      end else begin
        m_idx++;
      end
    end else begin
      if (!run) m_mode = 0;
      else if (step_req) begin m_mode = 1; m_idx = 0; end
    end
  endtask

  function automatic logic [31:0] exp_tp();
    return (m_mode == 1) ? (32'd1 << (m_idx / NPH)) : 32'd0;
  endfunction

  task automatic check_all();
    logic [31:0] ph;
    ph = m_idx % NPH;
    check("tp",        32'(tp),          exp_tp());
    check("ph1",       32'(ph1),         32'(m_mode == 1 && ph == 0));
    check("ph2",       32'(ph2),         32'(m_mode == 1 && ph == NPH - 1));
    check("mct_end",   32'(mct_end),     32'(m_mode == 1 && m_idx == L - 1));
    check("halted",    32'(halted),      32'(m_mode == 2));
    check("gojam_cyc", 32'(gojam_cycle), 32'(m_gc));
    check("mct_count", 32'(mct_count),   m_cnt & 32'hFFFF);
    check("tp_w",      32'(tp_w),        exp_tp());
    check("count_w",   32'(mct_count_w), m_cnt & 32'hF);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model reaches the requested mode/index, bounded
  task automatic run_until(input int mode, input int unsigned idx, input int unsigned budget,
                           input string tag);
    int unsigned k;
    k = 0;
    while (!(m_mode == mode && (mode != 1 || m_idx == idx)) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step_req = 1'b0; gojam = 1'b0;
    model_reset();
    #1;
    check_all();
    cycles(2);
    rst = 1'b0;

    // Free running: 10 back-to-back MCTs
    run = 1'b1;
    cycles(L * 10 + 1);
    check("cnt_after_10", 32'(mct_count), 32'd10);

    // Step mode: halt after each MCT, single step, then held step_req
    step_mode = 1'b1;
    cycles(L + 3);
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    cycles(L + 3);
    step_req = 1'b1;
    cycles(3 * (L + 1));
    step_req = 1'b0;
    step_mode = 1'b0;
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;

    // Drop run at T05: MCT must finish before IDLE
    run_until(1, 8, 4 * L, "to_t05");
    run = 1'b0;
    cycles(L + 5);

    // GOJAM at T07 phase 1
    run = 1'b1;
    run_until(1, 13, 4 * L, "to_t07");
    gojam = 1'b1;
    cycle();
    gojam = 1'b0;
    check("gj_tp", 32'(tp), 32'h001);
    check("gj_flag", 32'(gojam_cycle), 32'd1);
    cycles(L + 5);

    // GOJAM coincident with mct_end
    run_until(1, L - 1, 4 * L, "to_end");
    gojam = 1'b1;
    cycle();
    gojam = 1'b0;
    cycles(4);

    // GOJAM while halted
    step_mode = 1'b1;
    run_until(2, 0, 4 * L, "to_halt");
    gojam = 1'b1;
    cycle();
    gojam = 1'b0;
    step_mode = 1'b0;
    check("gj_halt_exit", 32'(halted), 32'd0);
    cycles(5);

    // GOJAM while idle has no effect
    run = 1'b0;
    run_until(0, 0, 4 * L, "to_idle");
    gojam = 1'b1;
    cycles(3);
    gojam = 1'b0;
    cycles(2);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 99) < 92);
      step_mode = ($urandom_range(0, 99) < 25);
      step_req  = ($urandom_range(0, 99) < 30);
      gojam     = ($urandom_range(0, 99) < 3);
      cycle();
    end
    run = 1'b1; step_mode = 1'b0; step_req = 1'b0; gojam = 1'b0;

    // Asynchronous reset in the middle of T09
    run_until(1, 16, 6 * L, "to_t09");
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_tp", 32'(tp), 32'd0);
    check("async_cnt", 32'(mct_count), 32'd0);
    check_all();
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    cycles(3);

    // 16 MCTs wrap the 4-bit counter to zero
    run = 1'b1;
    cycles(16 * L + 1);
    check("wrap_w", 32'(mct_count_w), 32'd0);
    check("wrap_16", 32'(mct_count), 32'd16);
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/agc_timepulse_ctrl.md
Name: agc_timepulse_ctrl

Overview:
- Sequencer for the gate-level AGC datapath. Generates the one-hot timepulse train T01..T12 that gates the NOR-network control logic.
- Each timepulse is subdivided into clock phases. Also provides memory-cycle (MCT) counting, single-MCT step/halt handshake, and GOJAM restart.
- Sits between the board clock and the control-pulse decode.

Parameters:
- NUM_TP, 12, timepulses per MCT (≥2)
- PHASES, 2, clk cycles per timepulse (≥2)
- CW, 16, width of MCT counter

Ports:
- clk  input  1  system clock, all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- run  input  1  level; 1 = sequencer may run
- step_mode  input  1  level; 1 = halt after every MCT
- step_req  input  1  in HALT, start one MCT
- gojam  input  1  restart request
- tp  output  NUM_TP  one-hot timepulse, bit0 = T01; all-zero when not running
- ph1  output  1  first phase of current timepulse
- ph2  output  1  last phase of current timepulse
- mct_end  output  1  high during final clk of an MCT
- halted  output  1  high in HALT state
- gojam_cycle  output  1  current MCT was started by GOJAM
- mct_count  output  CW  completed MCTs, wraps

Behaviour:
- Registered state: state (IDLE/RUN/HALT), tp, phase counter (0..PHASES-1), gojam_cycle, mct_count.
- Reset, asynchronous, immediate: state=IDLE, tp=0, phase=0, gojam_cycle=0, mct_count=0. Consequently ph1=ph2=mct_end=halted=0.
- Decoded outputs, combinational from registers only:
  - ph1 = running & phase==0
  - ph2 = running & phase==PHASES-1
  - mct_end = tp[NUM_TP-1] & phase==PHASES-1
  - halted = state==HALT
- IDLE:
  - tp=0.
  - run=1 at posedge → RUN, tp=T01, phase=0. No delay cycle.
  - gojam is ignored in IDLE.
- RUN:
  - phase increments each clk.
  - At phase==PHASES-1: phase←0, tp shifts up one bit.
  - Each timepulse lasts exactly PHASES clks; an MCT lasts NUM_TP*PHASES clks (24 by default).
- MCT completion, i.e. a posedge with mct_end=1, gojam=0:
  - mct_count increments, wrapping from 2^CW-1 to 0.
  - gojam_cycle←0.
  - Next state, priority order:
    - run=0 → IDLE, tp=0.
    - step_mode=1 → HALT, tp=0.
    - otherwise RUN, tp=T01, phase=0. Back-to-back, no gap.
- run dropping mid-MCT never truncates; the MCT completes first. Same for step_mode asserting mid-MCT.
- HALT:
  - tp=0, halted=1.
  - step_req=1 at posedge → RUN, tp=T01, phase=0, halted=0 next cycle.
  - run=0 → IDLE; this takes priority over step_req.
  - step_req is ignored outside HALT. step_req held high in HALT with step_mode=1 yields one MCT per HALT visit, each separated by exactly one HALT cycle.
- GOJAM, in RUN or HALT:
  - Highest priority; overrides completion and step logic.
  - Next posedge: state=RUN, tp=T01, phase=0, gojam_cycle=1.
  - mct_count is not incremented for the aborted MCT, even if gojam coincides with mct_end.
  - gojam held high re-restarts every clk; tp stays T01, phase stays 0.
- Reset asserted mid-MCT: outputs go to reset values without waiting for clk. After release, IDLE until run is sampled high.
- tp is always one-hot or zero; never more than one bit set.

Test Plan:
- Reset release, run=1, step_mode=0 → tp=0x001 on first posedge. tp=0x002 after 2 clks. mct_end high on clk 24 with tp=0x800. Next clk tp=0x001 and mct_count=1. After 10 MCTs (240 clks), mct_count=10.
- step_mode=1, run=1 → one MCT (24 clks), then halted=1, tp=0, mct_count=1. Pulse step_req for 1 clk → tp=0x001 next clk. After 24 clks, halted again with mct_count=2.
- Drop run at tp=0x010 → sequence continues through tp=0x800. Then tp=0, IDLE, mct_count incremented once. ph1/ph2 stay 0 afterwards.
- Assert gojam for 1 clk at tp=0x040, phase 1 → next clk tp=0x001, phase 0, gojam_cycle=1, mct_count unchanged. gojam_cycle clears at the end of the following MCT, when mct_count increments.
- gojam coincident with mct_end → tp=0x001, mct_count not incremented. gojam in HALT → RUN, halted=0. gojam in IDLE → no change.
- Assert rst asynchronously mid-clk at tp=0x100 → tp=0, mct_count=0 immediately. Set CW=4 and run 16 MCTs → mct_count wraps from 15 to 0.
